trees_multibuf_dispatch: RTL
============================

Name: trees_multibuf_dispatch

Overview:
- Parametrised multi-slot feature staging and dispatch engine for the tree-ensemble inference core.
- Streams feature vectors from a host-loaded feature RAM into an N_SLOTS-deep circular buffer of vector registers.
- Dispatches each vector to an external inference core via a start/done handshake.
- Packs per-sample predictions of PRED_W bits into WORD_W-bit words in a host-readable prediction RAM.
- Generalises double (ping-pong) buffering to N slots, with configurable feature/prediction widths and an abort mode.

Parameters:
- N_FEATURE, 32, features per sample vector.
- FEAT_W, 32, bits per feature.
- WORD_W, 64, host word width. Must be a multiple of FEAT_W and PRED_W.
- N_SLOTS, 4, vector buffer depth. Power of two, ≥2.
- MAX_BURST, 5000, maximum samples per burst.
- PRED_W, 8, prediction width per sample.

Derived values:
- FPW = WORD_W/FEAT_W.
- WPV = N_FEATURE/FPW (words per vector).
- PPW = WORD_W/PRED_W.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, begin burst (sampled only in IDLE).
- abort, in, 1, cancel burst.
- burst_len, in, clog2(MAX_BURST)+1, sample count, latched at start.
- load_features, in, 1, feature RAM write enable.
- feature_addr, in, clog2(MAX_BURST*WPV), feature RAM write address.
- features_in, in, WORD_W, feature RAM write data.
- core_start, out, 1, one-cycle launch pulse to the inference core.
- core_features, out, N_FEATURE*FEAT_W, vector presented to the core.
- core_idle, in, 1, core ready to accept a launch.
- core_done, in, 1, one-cycle result strobe.
- core_pred, in, PRED_W, result, valid with core_done.
- pred_addr, in, clog2(ceil(MAX_BURST/PPW)), prediction read address.
- prediction, out, WORD_W, combinational read of prediction RAM.
- busy, out, 1, burst in progress.
- done, out, 1, one-cycle burst-complete pulse.
- aborted, out, 1, one-cycle abort acknowledge.

Behaviour:
- Reset values: core_start=0, core_features=0, busy=0, done=0, aborted=0. All slot valid bits=0. wr_ptr=rd_ptr=0. Pack register=0. Sample counters=0. The RAMs themselves are not reset.
- Feature RAM:
  - Write-only port, active whenever load_features=1, regardless of state.
  - Synchronous read port, 1-cycle latency, owned by the copy engine.
  - Vector s occupies words s*WPV .. s*WPV+WPV-1. Within a word, lane k (bits k*FEAT_W+:FEAT_W) is feature s_word*FPW+k.
- Copy FSM states: C_IDLE, C_FILL, C_FULL.
  - C_IDLE + start → C_FILL. Latch burst_len; clear copy_cnt and word index.
  - C_FILL:
    - Issues one read per cycle into slot wr_ptr while slot[wr_ptr] is not valid.
    - On the last word written: set valid[wr_ptr], wr_ptr+1 mod N_SLOTS, copy_cnt+1.
    - Next vector's reads begin the following cycle, so there are no bubbles while free slots exist.
    - If slot[wr_ptr] is valid → C_FULL.
  - C_FULL: wait; return to C_FILL the cycle after that slot frees.
  - copy_cnt==burst_len → C_IDLE.
- Dispatch FSM states: D_IDLE, D_WAIT, D_RUN.
  - D_IDLE + start → D_WAIT.
  - D_WAIT: when valid[rd_ptr] && core_idle, pulse core_start for exactly 1 cycle, drive core_features from slot rd_ptr, → D_RUN.
  - D_RUN:
    - core_features stays stable until core_done.
    - On core_done:
      - Write core_pred into pack lane (pred_cnt mod PPW); pred_cnt+1.
      - Clear valid[rd_ptr]; rd_ptr+1.
      - → D_WAIT.
  - core_done outside D_RUN is ignored.
- Packing:
  - The prediction word is written to address pred_cnt/PPW when the lane index reaches PPW-1 or the sample is the last of the burst.
  - Unused lanes of a partial final word are 0.
  - The pack register clears after each write.
- Completion:
  - done pulses the cycle after the final prediction word is written. busy falls the same cycle.
  - burst_len=0: done pulses the cycle after start. No core_start is issued.
- Latency: with core_idle=1, the first core_start occurs WPV+2 cycles after the start cycle.
- Slot conflict: a slot freed and refilled on the same cycle is impossible. The copy engine sees the free flag one cycle late.
- start while busy is ignored.
- abort (any state, priority over all else):
  - Both FSMs → IDLE next cycle.
  - Valid bits and pointers cleared. The partial pack word is discarded.
  - aborted pulses 1 cycle. done is not asserted.
  - A later core_done is ignored.
- Asynchronous reset mid-burst returns everything to reset values immediately.

Test Plan:
- WPV=16, N_SLOTS=4, burst_len=1, vector 0 words = 0x1..0x10, core_idle=1, core_done 5 cycles after core_start with core_pred=0xA5 → core_start at cycle 18. core_features lane0=0x1. prediction[0]=0x00000000000000A5. done pulses once.
- burst_len=10, core latency 3, core_pred=sample index → prediction[0]=0x0706050403020100, prediction[1]=0x0000000000000908.
- Core latency 200 cycles, burst_len=8 → at most 4 vectors buffered, copy stalls in C_FULL, no slot overwritten. All 8 predictions are correct and in order.
- core_idle held low 50 cycles after start → no core_start until core_idle rises. Results are unchanged.
- abort asserted during third sample's D_RUN → aborted pulses, done never asserts, busy=0. A new start with burst_len=2 completes correctly.
- burst_len=0 → done next cycle, no core_start. start pulsed while busy → ignored, counts unchanged.

Source files
------------

// File: rtl/trees_multibuf_dispatch.sv
// Feature staging and dispatch engine for the tree-ensemble core.
// N-slot vector buffer between feature RAM and core; packs predictions.
module trees_multibuf_dispatch #(
  parameter int N_FEATURE = 32,
  parameter int FEAT_W    = 32,
  parameter int WORD_W    = 64,
  parameter int N_SLOTS   = 4,
  parameter int MAX_BURST = 5000,
  parameter int PRED_W    = 8,
  localparam int FPW    = WORD_W / FEAT_W,
  localparam int WPV    = N_FEATURE / FPW,
  localparam int PPW    = WORD_W / PRED_W,
  localparam int LEN_W  = $clog2(MAX_BURST) + 1,
  localparam int FDEPTH = MAX_BURST * WPV,
  localparam int FA_W   = $clog2(FDEPTH),
  localparam int PDEPTH = (MAX_BURST + PPW - 1) / PPW,
  localparam int PA_W   = $clog2(PDEPTH),
  localparam int VW     = N_FEATURE * FEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  burst_len,
  input  logic              load_features,
  input  logic [FA_W-1:0]   feature_addr,
  input  logic [WORD_W-1:0] features_in,
  output logic              core_start,
  output logic [VW-1:0]     core_features,
  input  logic              core_idle,
  input  logic              core_done,
  input  logic [PRED_W-1:0] core_pred,
  input  logic [PA_W-1:0]   pred_addr,
  output logic [WORD_W-1:0] prediction,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int SW   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
  localparam int WI_W = (WPV > 1) ? $clog2(WPV) : 1;
  localparam int LN_W = (PPW > 1) ? $clog2(PPW) : 1;

  typedef enum logic [1:0] {
    C_IDLE,
    C_FILL,
    C_FULL
  } c_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_RUN
  } d_state_t;

  c_state_t r_c_state, w_c_next;
  d_state_t r_d_state, w_d_next;

  logic [WORD_W-1:0] r_fmem [FDEPTH];
  logic [WORD_W-1:0] r_pmem [PDEPTH];
  logic [VW-1:0]     r_slot [N_SLOTS];

  logic [N_SLOTS-1:0] r_valid;
  logic [SW-1:0]      r_wr_ptr;
  logic [SW-1:0]      r_rd_ptr;
  logic [LEN_W-1:0]   r_len;
  logic [LEN_W-1:0]   r_copy_cnt;
  logic [LEN_W-1:0]   r_pred_cnt;
  logic [WI_W-1:0]    r_widx;
  logic               r_pend;
  logic               r_pend_last;
  logic [SW-1:0]      r_pend_slot;
  logic [WI_W-1:0]    r_pend_word;
  logic [WORD_W-1:0]  r_rdata;
  logic [WORD_W-1:0]  r_pack;
  logic               r_done;
  logic               r_aborted;

  logic               w_idle;
  logic               w_go;
  logic               w_zero;
  logic               w_issue;
  logic               w_vec_end;
  logic [FA_W-1:0]    w_raddr;
  logic               w_launch;
  logic               w_ret;
  logic [LN_W-1:0]    w_lane;
  logic               w_last;
  logic               w_flush;
  logic [PA_W-1:0]    w_paddr;
  logic [WORD_W-1:0]  w_packed;
  logic [N_SLOTS-1:0] w_set;
  logic [N_SLOTS-1:0] w_clr;

  assign w_idle = (r_c_state == C_IDLE) && (r_d_state == D_IDLE);
  assign w_go   = start && w_idle && !abort && (burst_len != '0);
  assign w_zero = start && w_idle && !abort && (burst_len == '0);

  assign w_issue = (r_c_state == C_FILL) && (r_copy_cnt != r_len)
                && !r_valid[r_wr_ptr] && !abort;
  assign w_vec_end = w_issue && (r_widx == WI_W'(WPV - 1));
  assign w_raddr = FA_W'(r_copy_cnt) * FA_W'(WPV) + FA_W'(r_widx);

  assign w_launch = (r_d_state == D_WAIT) && r_valid[r_rd_ptr]
                 && core_idle && !abort;
  assign w_ret    = (r_d_state == D_RUN) && core_done && !abort;

  assign w_lane  = LN_W'(r_pred_cnt % LEN_W'(PPW));
  assign w_last  = (LEN_W'(r_pred_cnt + LEN_W'(1)) == r_len);
  assign w_flush = w_ret && ((w_lane == LN_W'(PPW - 1)) || w_last);
  assign w_paddr = PA_W'(r_pred_cnt / LEN_W'(PPW));

  always_comb begin
    w_packed = r_pack;
    w_packed[w_lane*PRED_W +: PRED_W] = core_pred;
  end

  assign w_set = (r_pend && r_pend_last) ? (N_SLOTS'(1) << r_pend_slot) : '0;
  assign w_clr = w_ret ? (N_SLOTS'(1) << r_rd_ptr) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c_state <= C_IDLE;
      r_d_state <= D_IDLE;
    end else begin
      r_c_state <= w_c_next;
      r_d_state <= w_d_next;
    end
  end

  always_comb begin
    w_c_next = r_c_state;
    case (r_c_state)
      C_IDLE: if (w_go) w_c_next = C_FILL;
      C_FILL: begin
        if (r_copy_cnt == r_len)   w_c_next = C_IDLE;
        else if (r_valid[r_wr_ptr]) w_c_next = C_FULL;
      end
      C_FULL: if (!r_valid[r_wr_ptr]) w_c_next = C_FILL;
      default: w_c_next = C_IDLE;
    endcase
    if (abort) w_c_next = C_IDLE;
  end

  always_comb begin
    w_d_next = r_d_state;
    case (r_d_state)
      D_IDLE: if (w_go) w_d_next = D_WAIT;
      D_WAIT: if (w_launch) w_d_next = D_RUN;
      D_RUN:  if (w_ret) w_d_next = w_last ? D_IDLE : D_WAIT;
      default: w_d_next = D_IDLE;
    endcase
    if (abort) w_d_next = D_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_len       <= '0;
      r_copy_cnt  <= '0;
      r_pred_cnt  <= '0;
      r_widx      <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_pend_slot <= '0;
      r_pend_word <= '0;
      r_pack      <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else if (abort) begin
      r_valid     <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_copy_cnt  <= '0;
      r_pred_cnt  <= '0;
      r_widx      <= '0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_pack      <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b1;
    end else begin
      r_aborted   <= 1'b0;
      r_done      <= w_zero || (w_flush && w_last);
      r_pend      <= w_issue;
      r_pend_last <= w_vec_end;
      r_pend_slot <= r_wr_ptr;
      r_pend_word <= r_widx;
      r_valid     <= (r_valid | w_set) & ~w_clr;
      if (w_go) begin
        r_len      <= burst_len;
        r_copy_cnt <= '0;
        r_pred_cnt <= '0;
        r_widx     <= '0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end
      if (w_issue) begin
        if (w_vec_end) begin
          r_widx     <= '0;
          r_wr_ptr   <= r_wr_ptr + SW'(1);
          r_copy_cnt <= r_copy_cnt + LEN_W'(1);
        end else begin
          r_widx <= r_widx + WI_W'(1);
        end
      end
      if (w_ret) begin
        r_rd_ptr   <= r_rd_ptr + SW'(1);
        r_pred_cnt <= r_pred_cnt + LEN_W'(1);
        r_pack     <= w_flush ? '0 : w_packed;
      end
    end
  end

  // Storage arrays carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (load_features) r_fmem[feature_addr] <= features_in;
    r_rdata <= r_fmem[w_raddr];
    if (r_pend) r_slot[r_pend_slot][r_pend_word*WORD_W +: WORD_W] <= r_rdata;
    if (w_flush) r_pmem[w_paddr] <= w_packed;
  end

  assign core_start    = w_launch;
  assign core_features = (r_d_state == D_IDLE) ? '0 : r_slot[r_rd_ptr];
  assign prediction    = r_pmem[pred_addr];
  assign busy          = (r_d_state != D_IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;

endmodule
